// File: rtl/iris_pkg.sv
// Shared types and constants for the Iris output-stage classifier.
package iris_pkg;

    localparam int unsigned SCORE_OFS = 6;

    localparam logic [1:0] CLS_SETOSA     = 2'd0;
    localparam logic [1:0] CLS_VERSICOLOR = 2'd1;
    localparam logic [1:0] CLS_VIRGINICA  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP2 = 2'd1,
        ST_CMP3 = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

endpackage

// File: rtl/iris_sat_counter.sv
// Saturating up-counter with synchronous clear that takes priority over increment.
module iris_sat_counter #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] cnt_o
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            if (clr) begin
                cnt_d = '0;
            end else if (inc && (cnt_q != {CNT_WIDTH{1'b1}})) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/iris_argmax_decider.sv
// Captures the three Iris class scores on layer-3 completion, picks the winner with a
// two-step strict compare, and presents it on a valid/ack handshake with per-class tallies.
module iris_argmax_decider
    import iris_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SCORE_WIDTH = DATA_WIDTH + SCORE_OFS,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          En,
    input  logic                          Ready_L3,
    input  logic signed [SCORE_WIDTH-1:0] Y1,
    input  logic signed [SCORE_WIDTH-1:0] Y2,
    input  logic signed [SCORE_WIDTH-1:0] Y3,
    input  logic                          Ack,
    input  logic                          Clr_Stats,
    output logic [1:0]                    Class,
    output logic signed [SCORE_WIDTH-1:0] Score,
    output logic                          Valid,
    output logic                          Overrun,
    output logic [CNT_WIDTH-1:0]          Cnt0,
    output logic [CNT_WIDTH-1:0]          Cnt1,
    output logic [CNT_WIDTH-1:0]          Cnt2
);

    state_e                         state_q, state_d;
    logic                           rdy_q, rdy_d;
    logic signed [SCORE_WIDTH-1:0]  y2_q, y2_d;
    logic signed [SCORE_WIDTH-1:0]  y3_q, y3_d;
    logic signed [SCORE_WIDTH-1:0]  best_q, best_d;
    logic [1:0]                     best_idx_q, best_idx_d;
    logic [1:0]                     class_q, class_d;
    logic signed [SCORE_WIDTH-1:0]  score_q, score_d;
    logic                           valid_q, valid_d;
    logic                           overrun_q, overrun_d;

    logic                           cap_c;
    logic                           ovr_evt_c;
    logic [2:0]                     inc_c;
    logic signed [SCORE_WIDTH-1:0]  win_score_c;
    logic [1:0]                     win_idx_c;

    assign cap_c = En & Ready_L3 & ~rdy_q;

    // Next-state, compare datapath and event decode.
    always_comb begin
        state_d     = state_q;
        rdy_d       = rdy_q;
        y2_d        = y2_q;
        y3_d        = y3_q;
        best_d      = best_q;
        best_idx_d  = best_idx_q;
        class_d     = class_q;
        score_d     = score_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;
        ovr_evt_c   = 1'b0;
        inc_c       = 3'b000;
        win_score_c = best_q;
        win_idx_c   = best_idx_q;

        if (y3_q > best_q) begin
            win_score_c = y3_q;
            win_idx_c   = CLS_VIRGINICA;
        end

        if (En) begin
            rdy_d = Ready_L3;
            unique case (state_q)
                ST_IDLE: begin
                    if (cap_c) begin
                        y2_d       = Y2;
                        y3_d       = Y3;
                        best_d     = Y1;
                        best_idx_d = CLS_SETOSA;
                        state_d    = ST_CMP2;
                    end
                end
                ST_CMP2: begin
                    if (y2_q > best_q) begin
                        best_d     = y2_q;
                        best_idx_d = CLS_VERSICOLOR;
                    end
                    ovr_evt_c = cap_c;
                    state_d   = ST_CMP3;
                end
                ST_CMP3: begin
                    best_d          = win_score_c;
                    best_idx_d      = win_idx_c;
                    class_d         = win_idx_c;
                    score_d         = win_score_c;
                    valid_d         = 1'b1;
                    inc_c[win_idx_c] = 1'b1;
                    ovr_evt_c       = cap_c;
                    state_d         = ST_HOLD;
                end
                ST_HOLD: begin
                    if (Ack) begin
                        valid_d = 1'b0;
                        state_d = ST_IDLE;
                        // A fresh result arriving with the ack counts as accepted, not dropped.
                        if (cap_c) begin
                            y2_d       = Y2;
                            y3_d       = Y3;
                            best_d     = Y1;
                            best_idx_d = CLS_SETOSA;
                            state_d    = ST_CMP2;
                        end
                    end else begin
                        ovr_evt_c = cap_c;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (Clr_Stats) begin
                overrun_d = 1'b0;
            end else if (ovr_evt_c) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            rdy_q      <= 1'b0;
            y2_q       <= '0;
            y3_q       <= '0;
            best_q     <= '0;
            best_idx_q <= CLS_SETOSA;
            class_q    <= CLS_SETOSA;
            score_q    <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdy_q      <= rdy_d;
            y2_q       <= y2_d;
            y3_q       <= y3_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            class_q    <= class_d;
            score_q    <= score_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    logic [CNT_WIDTH-1:0] cnt_w [3];

    for (genvar g = 0; g < 3; g++) begin : g_tally
        iris_sat_counter #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst),
            .en    (En),
            .clr   (Clr_Stats),
            .inc   (inc_c[g]),
            .cnt_o (cnt_w[g])
        );
    end

    assign Class   = class_q;
    assign Score   = score_q;
    assign Valid   = valid_q;
    assign Overrun = overrun_q;
    assign Cnt0    = cnt_w[0];
    assign Cnt1    = cnt_w[1];
    assign Cnt2    = cnt_w[2];

endmodule
